poly_arbiter: RTL and testbench

POLY_ARBITER -- requirements
Module: poly_arbiter

---
 rtl/poly_arbiter.sv | 130 +++++++++++++
 tb/tb_poly_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/poly_arbiter.sv
// poly_arbiter: two-requester arbiter computing A*x*x + B*x + C mod 2^WIDTH on one shared multiplier and adder.
// Define POLY_ARB_RR_EN for round-robin on contention; otherwise requester 0 has fixed priority.
module poly_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] c0,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] c1,
    input  logic [WIDTH-1:0] x1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result0,
    output logic [WIDTH-1:0] result1,
    output logic             busy,
    output logic             grant_id
);
    typedef enum logic [2:0] {IDLE, MUL_AX, MUL_AXX, MUL_BX, ADD1, ADD2, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, c_q, x_q, t_q, u_q, res0_q, res1_q;
    logic [WIDTH-1:0] a_d, b_d, c_d, x_d, t_d, u_d, res0_d, res1_d;
    logic             gid_q, gid_d, last_q, last_d, win;
    logic [WIDTH-1:0] mul_l, prod, add_r, sum;

`ifdef POLY_ARB_RR_EN
    assign win = (req0 && req1) ? ~last_q : ~req0;
`else
    assign win = ~req0;
`endif

    // Shared datapath: the state selects which operands feed the multiplier and adder.
    assign mul_l = (state_q == MUL_AX) ? a_q : (state_q == MUL_AXX) ? t_q : b_q;
    assign prod  = mul_l * x_q;
    assign add_r = (state_q == ADD1) ? u_q : c_q;
    assign sum   = t_q + add_r;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        x_d     = x_q;
        t_d     = t_q;
        u_d     = u_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        gid_d   = gid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (req0 || req1) begin
                state_d = MUL_AX;
                gid_d   = win;
                last_d  = win;
                a_d     = win ? a1 : a0;
                b_d     = win ? b1 : b0;
                c_d     = win ? c1 : c0;
                x_d     = win ? x1 : x0;
            end
            MUL_AX: begin
                state_d = MUL_AXX;
                t_d     = prod;
            end
            MUL_AXX: begin
                state_d = MUL_BX;
                t_d     = prod;
            end
            MUL_BX: begin
                state_d = ADD1;
                u_d     = prod;
            end
            ADD1: begin
                state_d = ADD2;
                t_d     = sum;
            end
            ADD2: begin
                state_d = DONE;
                res0_d  = gid_q ? res0_q : sum;
                res1_d  = gid_q ? sum : res1_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            x_q     <= '0;
            t_q     <= '0;
            u_q     <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            x_q     <= x_d;
            t_q     <= t_d;
            u_q     <= u_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
        end
    end

    assign ack0     = (state_q == MUL_AX) && !gid_q;
    assign ack1     = (state_q == MUL_AX) && gid_q;
    assign done0    = (state_q == DONE) && !gid_q;
    assign done1    = (state_q == DONE) && gid_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = gid_q;
    assign result0  = res0_q;
    assign result1  = res1_q;
endmodule

// File: tb/tb_poly_arbiter.sv
// tb_poly_arbiter: directed and random jobs for poly_arbiter, checked against a job-level reference model.
module tb_poly_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, c0 = '0, x0 = '0;
    logic [W-1:0] a1 = '0, b1 = '0, c1 = '0, x1 = '0;
    logic         ack0, ack1, done0, done1, busy, grant_id;
    logic [W-1:0] result0, result1;

    int           total = 0, bad = 0;
    logic         last_m = 1'b1;
    logic [W-1:0] res_m[2] = '{default: '0};

    always #5 clk = ~clk;

    poly_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .c0(c0), .x0(x0),
        .a1(a1), .b1(b1), .c1(c1), .x1(x1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result0(result0), .result1(result1), .busy(busy), .grant_id(grant_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Polynomial evaluated in wide integer arithmetic, reduced once at the end.
    function automatic logic [W-1:0] poly(input int unsigned a, b, c, x);
        int unsigned r;
        r = a * x * x + b * x + c;
        return W'(r % (32'd1 << W));
    endfunction

    function automatic logic pick(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef POLY_ARB_RR_EN
            return (last_m == 1'b0) ? 1'b1 : 1'b0;
`else
            return 1'b0;
`endif
        end
        return r1 ? 1'b1 : 1'b0;
    endfunction

    task automatic set_ops(input int p, input logic [W-1:0] a, b, c, x);
        if (p == 0) begin a0 = a; b0 = b; c0 = c; x0 = x; end
        else begin a1 = a; b1 = b; c1 = c; x1 = x; end
    endtask

    task automatic rand_ops();
        set_ops(0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        set_ops(1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    // Runs one job from an IDLE cycle; noise scrambles reqs and operands mid-job.
    task automatic do_job(input logic r0, input logic r1, input logic noise, output logic w);
        logic [W-1:0] exp;
        w = pick(r0, r1);
        req0 = r0;
        req1 = r1;
        exp = w ? poly(a1, b1, c1, x1) : poly(a0, b0, c0, x0);
        tick();
        last_m = w;
        res_m[w] = exp;
        check("ack0", ack0, !w);
        check("ack1", ack1, w);
        check("grant_id", grant_id, w);
        check("busy_job", busy, 1);
        for (int k = 0; k < 5; k++) begin
            if (noise) begin
                req0 = 1'($urandom_range(0, 1));
                req1 = 1'($urandom_range(0, 1));
                rand_ops();
            end
            tick();
            if (k < 4) check("quiet_mid", {done0, done1, ack0, ack1}, 0);
        end
        check("done0", done0, !w);
        check("done1", done1, w);
        check("result0", result0, res_m[0]);
        check("result1", result1, res_m[1]);
        req0 = r0;
        req1 = r1;
        tick();
        check("idle_after", {busy, done0, done1}, 0);
    endtask

    initial begin
        logic       w;
        logic [2:0] g;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_acks", {ack0, ack1, done0, done1}, 0);
        check("rst_gid", grant_id, 0);
        check("rst_res0", result0, 0);
        check("rst_res1", result1, 0);
        reset = 1'b0;
        tick();

        set_ops(0, 2, 3, 4, 5);
        do_job(1, 0, 0, w);
        check("s1_result0", result0, 69);
        check("s1_result1", result1, 0);
        req0 = 0;
        tick();

        set_ops(1, 10, 0, 0, 10);
        do_job(0, 1, 0, w);
        check("s2_result1", result1, 232);
        check("s2_gid", grant_id, 1);
        req1 = 0;
        tick();

        for (int j = 0; j < 3; j++) begin
            rand_ops();
            do_job(1, 1, 0, w);
            g[j] = w;
        end
`ifdef POLY_ARB_RR_EN
        check("s3_grants", g, 3'b010);
`else
        check("s3_grants", g, 3'b000);
`endif
        req0 = 0;
        req1 = 0;
        tick();

        set_ops(0, 255, 255, 255, 255);
        do_job(1, 0, 0, w);
        check("s6_result0", result0, 255);
        req0 = 0;
        tick();

        rand_ops();
        do_job(0, 1, 1, w);
        req1 = 0;
        tick();

        rand_ops();
        req0 = 1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        last_m = 1'b1;
        res_m = '{default: '0};
        check("s4_busy", busy, 0);
        check("s4_results", {result0, result1}, 0);
        check("s4_gid", grant_id, 0);
        reset = 1'b0;
        req0 = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("s4_no_done", {busy, done0, done1}, 0);
        end
        set_ops(0, 1, 2, 3, 4);
        do_job(1, 0, 0, w);
        check("s4_after", result0, 27);
        req0 = 0;
        tick();

        for (int j = 0; j < 30; j++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            rand_ops();
            do_job(r[0], r[1], 1'($urandom_range(0, 1)), w);
            if ($urandom_range(0, 2) == 0) begin
                req0 = 0;
                req1 = 0;
                tick();
                check("rand_idle", {busy, ack0, ack1}, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
